// File: rtl/jcb_merge_arbiter.sv
// Pulse-merge scheduler: per-source backlog counters, round-robin replay with fixed spacing.
// Optional statistics outputs fire_cnt/drop_cnt when JCB_ARB_STAT_EN is defined.
module jcb_merge_arbiter #(
  parameter  int N_REQ = 2,
  parameter  int CNT_W = 3,
  parameter  int GAP   = 3,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic             dout,
  output logic [SRC_W-1:0] dout_src,
  output logic             pending,
  output logic [N_REQ-1:0] ovf
`ifdef JCB_ARB_STAT_EN
  ,
  output logic [15:0]      fire_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int HOLD_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SRC_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt     [N_REQ];
  logic [CNT_W-1:0]  cnt_nxt [N_REQ];

  logic              found;
  logic [SRC_W-1:0]  winner;
  logic              grant_ok;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  drop;
  logic [SRC_W-1:0]  rr_nxt;

  // Round-robin search from rr_ptr over the pre-increment counters
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && cnt[idx] != '0) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  assign grant_ok = (state == IDLE) && enable && found;
  assign rr_nxt   = (winner == SRC_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  // Per-source counter next-state, grant decode and overflow detection
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant[i]   = grant_ok && (winner == SRC_W'(i));
      drop[i]    = 1'b0;
      cnt_nxt[i] = cnt[i];
      if (req_pulse[i] && !grant[i]) begin
        if (cnt[i] == CNT_MAX) drop[i] = 1'b1;
        else cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (!req_pulse[i] && grant[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Backlog counters, pending flag and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      pending <= 1'b0;
      ovf     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_nxt[i];
      pending <= found;
      ovf     <= (clr_ovf ? '0 : ovf) | drop;
    end
  end

  // Issue FSM: one pulse, then hold off for GAP-1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      dout     <= 1'b0;
      dout_src <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (grant_ok) begin
            dout     <= 1'b1;
            dout_src <= winner;
            rr_ptr   <= rr_nxt;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end else begin
            dout <= 1'b0;
          end
        end
        state == HOLD: begin
          dout     <= 1'b0;
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HOLD_LAST) state <= IDLE;
        end
        default: begin
          dout  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef JCB_ARB_STAT_EN
  logic [15:0] drop_add;
  logic [16:0] drop_sum;

  // Number of requests dropped this cycle across all sources
  always_comb begin
    drop_add = '0;
    for (int i = 0; i < N_REQ; i++) drop_add = drop_add + 16'(drop[i]);
    drop_sum = {1'b0, drop_cnt} + {1'b0, drop_add};
  end

  // Fire counter wraps, drop counter saturates; clr_ovf clears both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt <= '0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      fire_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (grant_ok) fire_cnt <= fire_cnt + 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_jcb_merge_arbiter.sv
// Directed bench for jcb_merge_arbiter with an expected-pulse scoreboard.
// Define JCB_ARB_STAT_EN to also check fire_cnt/drop_cnt.
module tb_jcb_merge_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_pulse = '0;
  logic       enable = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       dout;
  logic [0:0] dout_src;
  logic       pending;
  logic [1:0] ovf;
`ifdef JCB_ARB_STAT_EN
  logic [15:0] fire_cnt;
  logic [15:0] drop_cnt;
`endif

  typedef struct {
    int cyc;
    int src;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  jcb_merge_arbiter #(
    .N_REQ(2),
    .CNT_W(3),
    .GAP  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_pulse(req_pulse),
    .enable   (enable),
    .clr_ovf  (clr_ovf),
    .dout     (dout),
    .dout_src (dout_src),
    .pending  (pending),
`ifdef JCB_ARB_STAT_EN
    .fire_cnt (fire_cnt),
    .drop_cnt (drop_cnt),
`endif
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("dout_pulse", 32'(dout), 1);
      check("dout_src", 32'(dout_src), e.src);
    end else begin
      check("dout_quiet", 32'(dout), 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    check("sb_drained", sb.size(), 0);
    sb.delete();
    req_pulse = '0;
    clr_ovf   = 1'b0;
    enable    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_src", 32'(dout_src), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_ovf", 32'(ovf), 0);
`ifdef JCB_ARB_STAT_EN
    check("rst_fire", 32'(fire_cnt), 0);
    check("rst_drop", 32'(drop_cnt), 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int t;
    #2;
    do_reset();

    // single request: pulse two cycles later, pending lags one cycle
    enable = 1'b1;
    step();
    step();
    t = cyc;
    req_pulse = 2'b01;
    sb.push_back('{cyc: t + 2, src: 0});
    step();
    req_pulse = 2'b00;
    step();
    check("single_pend_hi", 32'(pending), 1);
    step();
    check("single_pend_lo", 32'(pending), 0);
    repeat (3) step();

    // simultaneous requests from a fresh rr pointer
    do_reset();
    enable = 1'b1;
    step();
    t = cyc;
    req_pulse = 2'b11;
    sb.push_back('{cyc: t + 2, src: 0});
    sb.push_back('{cyc: t + 5, src: 1});
    step();
    req_pulse = 2'b00;
    repeat (8) step();

    // overflow on src1 while disabled, then drain at GAP spacing
    do_reset();
    repeat (8) begin
      req_pulse = 2'b10;
      step();
    end
    req_pulse = 2'b00;
    check("ovf_src1", 32'(ovf), 2);
    check("ovf_pend", 32'(pending), 1);
`ifdef JCB_ARB_STAT_EN
    check("stat_drop1", 32'(drop_cnt), 1);
`endif
    enable = 1'b1;
    t = cyc;
    for (int k = 0; k < 7; k++) sb.push_back('{cyc: t + 1 + 3 * k, src: 1});
    repeat (24) step();
    check("ovf_sticky", 32'(ovf), 2);
    check("drain_pend", 32'(pending), 0);
`ifdef JCB_ARB_STAT_EN
    check("stat_fire7", 32'(fire_cnt), 7);
`endif
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
`ifdef JCB_ARB_STAT_EN
    check("stat_fire_clr", 32'(fire_cnt), 0);
    check("stat_drop_clr", 32'(drop_cnt), 0);
`endif

    // overflow in the same cycle as clr_ovf keeps the flag set
    enable = 1'b0;
    repeat (8) begin
      req_pulse = 2'b01;
      step();
    end
    check("ovf_src0", 32'(ovf), 1);
    req_pulse = 2'b01;
    clr_ovf   = 1'b1;
    step();
    req_pulse = 2'b00;
    clr_ovf   = 1'b0;
    check("ovf_set_wins", 32'(ovf), 1);
`ifdef JCB_ARB_STAT_EN
    check("stat_drop_lost", 32'(drop_cnt), 0);
`endif
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(ovf), 0);
    enable = 1'b1;
    t = cyc;
    for (int k = 0; k < 7; k++) sb.push_back('{cyc: t + 1 + 3 * k, src: 0});
    repeat (24) step();

    // fairness: both sources request every 6 cycles
    do_reset();
    enable = 1'b1;
    step();
    t = cyc;
    for (int p = 0; p < 4; p++) begin
      sb.push_back('{cyc: t + 2 + 6 * p, src: 0});
      sb.push_back('{cyc: t + 5 + 6 * p, src: 1});
    end
    for (int p = 0; p < 4; p++) begin
      req_pulse = 2'b11;
      step();
      req_pulse = 2'b00;
      repeat (5) step();
    end
    repeat (4) step();
    check("fair_no_ovf", 32'(ovf), 0);

    // reset while a pulse is on dout and a backlog is queued
    do_reset();
    repeat (8) begin
      req_pulse = 2'b01;
      step();
    end
    req_pulse = 2'b00;
    check("pre_rst_ovf", 32'(ovf), 1);
    enable = 1'b1;
    step();
    check("pre_rst_dout", 32'(dout), 1);
    check("pre_rst_src", 32'(dout_src), 0);
    do_reset();
    enable = 1'b1;
    repeat (10) step();
    check("post_rst_pend", 32'(pending), 0);
    check("post_rst_ovf", 32'(ovf), 0);
    check("sb_final", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
